branch_cmp_unit: RTL and testbench

//   Parametrised branch-condition unit for the CPU branch path. Evaluates one of eight

---
 rtl/branch_cmp_unit.sv | 140 ++++++++++++++
 tb/tb_branch_cmp_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_unit.sv
// Branch-condition unit: evaluates one of eight compares on two operands and queues the result, plus a count of taken branches.
// Latency: a request accepted on a rising edge appears at the queue head (out_*) right after that edge.
// Backpressure: a 2-entry result queue; in_ready depends only on the occupancy count (it drops when full) and never on out_ready.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid/in_ready             request handshake; in_op, in_a, in_b, in_tag are the request fields
//   flush                         synchronous discard of every queued result (wins over push/pop)
//   out_valid/out_ready           result handshake; out_taken, out_equal, out_neg, out_tag come from the head entry
//   cnt_clr, taken_count          synchronous clear and saturating count of taken results that were popped
module branch_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_equal,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LTZ = 3'b010,
        OP_GEZ = 3'b011,
        OP_GTZ = 3'b100,
        OP_LEZ = 3'b101,
        OP_LT  = 3'b110,
        OP_LTU = 3'b111
    } op_e;

    typedef struct packed {
        logic             taken;
        logic             equal;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t       head;      // oldest entry, drives out_*
    res_t       tail;      // second entry, only meaningful when count==2
    res_t       new_res;
    logic [1:0] count;
    logic       push;
    logic       pop;

    logic a_zero;
    logic a_neg;
    logic a_eq;
    logic lt_s;
    logic lt_u;
    logic taken;

    always_comb begin
        a_zero = (in_a == '0);
        a_neg  = in_a[WIDTH-1];
        a_eq   = (in_a == in_b);
        lt_s   = ($signed(in_a) < $signed(in_b));
        lt_u   = (in_a < in_b);
        taken  = 1'b0;
        case (op_e'(in_op))
            OP_EQ:   taken = a_eq;
            OP_NE:   taken = !a_eq;
            OP_LTZ:  taken = a_neg;
            OP_GEZ:  taken = !a_neg;
            OP_GTZ:  taken = !a_neg && !a_zero;
            OP_LEZ:  taken = a_neg || a_zero;
            OP_LT:   taken = lt_s;
            OP_LTU:  taken = lt_u;
            default: taken = 1'b0;
        endcase
        new_res = '{taken: taken, equal: a_eq, neg: a_neg, tag: in_tag};
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_taken = head.taken;
    assign out_equal = head.equal;
    assign out_neg   = head.neg;
    assign out_tag   = head.tag;

    // The head stays in place after the last pop so out_* hold their final value while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= new_res;
                    end else begin
                        tail <= new_res;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                // Push and pop together only happens with count==1: the new entry replaces the head.
                2'b11: head <= new_res;
                default: ;
            endcase
        end
    end

    // Flushed entries are discarded, never counted, so a pop under flush is ignored here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_count <= '0;
        end else if (cnt_clr) begin
            taken_count <= '0;
        end else if (pop && !flush && head.taken && (taken_count != {CNT_W{1'b1}})) begin
            taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_cmp_unit.sv
module tb_branch_cmp_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_taken;
    logic             out_equal;
    logic             out_neg;
    logic [TAG_W-1:0] out_tag;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] taken_count;

    int total = 0;
    int bad = 0;

    branch_cmp_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_equal(out_equal), .out_neg(out_neg),
        .out_tag(out_tag), .cnt_clr(cnt_clr), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       taken;
        bit       equal;
        bit       neg;
        bit [4:0] tag;
    } ent_t;

    ent_t q[$];
    int   mcnt = 0;
    bit   clean = 1'b1;   // nothing pushed since reset: out_* must read zero

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (op)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd2: return sa < 0;
            3'd3: return sa >= 0;
            3'd4: return sa > 0;
            3'd5: return sa <= 0;
            3'd6: return sa < sb;
            default: return ua < ub;
        endcase
    endfunction

    always @(negedge reset_n) begin
        q.delete();
        mcnt = 0;
        clean = 1'b1;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            bit   do_push;
            bit   do_pop;
            ent_t e;
            ent_t h;
            do_push = in_valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && out_ready;
            if (do_pop) h = q[0];
            if (cnt_clr) mcnt = 0;
            else if (do_pop && !flush && h.taken && mcnt < CNT_MAX) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e.taken = ref_taken(in_op, in_a, in_b);
                    e.equal = (in_a == in_b);
                    e.neg   = ($signed(in_a) < 0);
                    e.tag   = in_tag;
                    q.push_back(e);
                    clean = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_taken_count", taken_count, 0);
            chk("rst_out_fields", {out_taken, out_equal, out_neg, out_tag}, 0);
        end else begin
            chk("in_ready", in_ready, (q.size() < 2));
            chk("out_valid", out_valid, (q.size() > 0));
            chk("taken_count", taken_count, mcnt);
            if (q.size() > 0) begin
                chk("out_taken", out_taken, q[0].taken);
                chk("out_equal", out_equal, q[0].equal);
                chk("out_neg", out_neg, q[0].neg);
                chk("out_tag", out_tag, q[0].tag);
            end else if (clean) begin
                chk("idle_out_fields", {out_taken, out_equal, out_neg, out_tag}, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_tag = tag;
    endtask

    initial begin
        int exp_sweep[8];
        logic pend;
        exp_sweep = '{0, 1, 1, 0, 0, 1, 1, 0};

        repeat (3) step();
        chk("t0_reset_valid", out_valid, 0);
        chk("t0_reset_ready", in_ready, 1);
        chk("t0_reset_count", taken_count, 0);
        reset_n = 1'b1;

        // 1: EQ with equal operands, consumer always ready
        set_req(3'd0, 32'h1234_5678, 32'h1234_5678, 5'd3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_taken", out_taken, 1);
        chk("t1_equal", out_equal, 1);
        step();
        chk("t1_count", taken_count, 1);

        // 2: op sweep, A=-1 B=1, then A=0
        for (int op = 0; op < 8; op++) begin
            set_req(3'(op), 32'hFFFF_FFFF, 32'h0000_0001, 5'(op));
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("t2_sweep_taken", out_taken, exp_sweep[op]);
            step();
        end
        set_req(3'd4, 32'd0, 32'd5, 5'd1); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("t2_gtz_zero", out_taken, 0); step();
        set_req(3'd5, 32'd0, 32'd5, 5'd2); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("t2_lez_zero", out_taken, 1); step();
        set_req(3'd3, 32'd0, 32'd5, 5'd3); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("t2_gez_zero", out_taken, 1); step();

        // 3: backpressure and ordering
        out_ready = 1'b0;
        set_req(3'd1, 32'd7, 32'd8, 5'd1); in_valid = 1'b1; step();
        set_req(3'd1, 32'd7, 32'd8, 5'd2); step();
        set_req(3'd1, 32'd7, 32'd8, 5'd3);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_head1", out_tag, 1);
        step(); step();
        chk("t3_held_ready", in_ready, 0);
        chk("t3_held_head", out_tag, 1);
        out_ready = 1'b1;
        step();
        chk("t3_head2", out_tag, 2);
        step();
        in_valid = 1'b0;
        chk("t3_head3", out_tag, 3);
        chk("t3_valid3", out_valid, 1);
        step();
        chk("t3_drained", out_valid, 0);

        // 4: simultaneous push/pop at count=1, then flush with a request offered
        out_ready = 1'b0;
        set_req(3'd0, 32'd1, 32'd1, 5'd4); in_valid = 1'b1; step();
        set_req(3'd0, 32'd1, 32'd1, 5'd5); out_ready = 1'b1; step();
        chk("t4_head5", out_tag, 5);
        chk("t4_valid", out_valid, 1);
        chk("t4_ready", in_ready, 1);
        set_req(3'd0, 32'd1, 32'd1, 5'd6); out_ready = 1'b0; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_flushed", out_valid, 0);
        step();
        chk("t4_dropped", out_valid, 0);

        // 5: saturation and clear priority
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("t5_cleared", taken_count, 0);
        set_req(3'd0, 32'd9, 32'd9, 5'd7);
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (9) step();
        in_valid = 1'b0;
        step();
        chk("t5_saturated", taken_count, 7);
        out_ready = 1'b0; in_valid = 1'b1; step();
        in_valid = 1'b0; cnt_clr = 1'b1; out_ready = 1'b1; step();
        cnt_clr = 1'b0;
        chk("t5_clr_wins", taken_count, 0);
        chk("t5_popped", out_valid, 0);

        // 6: asynchronous reset with a full queue
        set_req(3'd0, 32'h8000_0001, 32'h8000_0001, 5'd9);
        in_valid = 1'b1; step(); in_valid = 1'b0; step();   // one taken pop for a nonzero count
        out_ready = 1'b0; in_valid = 1'b1; step(); step();
        in_valid = 1'b0;
        chk("t6_full", in_ready, 0);
        chk("t6_count_before", taken_count, 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_fields", {out_taken, out_equal, out_neg, out_tag}, 0);
        chk("t6_count", taken_count, 0);
        step();
        reset_n = 1'b1;

        // random traffic against the model
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                logic [31:0] a;
                logic [31:0] b;
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: a = 32'd0;
                    2: begin a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0}; b = 32'($urandom_range(0, 3)); end
                    default: ;
                endcase
                set_req(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            pend = in_valid && !in_ready && !flush;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
